fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port i_stall, input, 1 bit: hold PC, state and all outputs.
REQ-004 SHALL have port i_flush, input, 1 bit: replace next output with a bubble.
REQ-005 SHALL have port i_branch, input, 1 bit: redirect fetch to i_branch_target.
REQ-006 SHALL have port i_branch_target, input, 16 bits: redirect address.
REQ-007 SHALL have port i_interrupt, input, 1 bit: external interrupt request, level-sampled each cycle.
REQ-008 SHALL have port o_imem_addr, output, 16 bits: instruction memory word address, combinational.
REQ-009 SHALL have port i_imem_data, input, 16 bits: instruction memory word at o_imem_addr, same cycle.
REQ-010 SHALL have port o_instr, output, 16 bits: instruction word to the decode stage.
REQ-011 SHALL have port o_imm, output, 16 bits: immediate word for two-word instructions, else 0.
REQ-012 SHALL have port o_pc, output, 16 bits: instruction address, or return address for interrupt bubbles.
REQ-013 SHALL have port o_valid, output, 1 bit: o_instr is a real instruction or interrupt bubble.
REQ-014 SHALL have port o_interrupt, output, 1 bit: output slot is an interrupt bubble; feeds decode i_interrupt.

Function
REQ-015 SHALL implement FSM states RST_VEC, FETCH, IMM, INT.
REQ-016 RST_VEC SHALL drive o_imem_addr=0x0000, load PC from i_imem_data, emit a bubble, then go to FETCH.
REQ-017 FETCH SHALL drive o_imem_addr=PC and increment PC by 1 (mod 2^16).
REQ-018 In FETCH, a single-word opcode SHALL register o_instr=word, o_pc=PC, o_imm=0, o_valid=1 one cycle later.
REQ-019 In FETCH, an opcode (bits 15:11) in the package IMM_OPCODES set SHALL latch the word, emit a bubble and go to IMM.
REQ-020 IMM SHALL read the word at PC, increment PC, and register o_instr=latched word, o_imm=word, o_pc=first-word address, o_valid=1; then go to FETCH.
REQ-021 A rising i_interrupt sample SHALL set a pending flag; it SHALL be taken only in FETCH at an instruction boundary, never between the words of a two-word instruction.
REQ-022 Taking an interrupt SHALL enter INT instead of fetching and clear the pending flag.
REQ-023 INT SHALL drive o_imem_addr=0x0001, load PC from i_imem_data, and emit o_valid=1, o_interrupt=1, o_instr=NOP, o_pc=un-incremented PC (return address); then go to FETCH.
REQ-024 Bubble SHALL mean o_valid=0, o_interrupt=0, o_instr=NOP (0x0000), o_imm=0, o_pc=0.
REQ-025 Priority SHALL be reset > branch > stall > flush > interrupt > normal fetch.
REQ-026 i_branch SHALL set PC=i_branch_target, emit a bubble, go to FETCH (aborting IMM), and override i_stall.
REQ-027 i_stall SHALL freeze PC, state, pending flag and outputs; the pending flag SHALL still be set by a new i_interrupt.
REQ-028 i_flush without i_branch SHALL emit a bubble but SHALL still advance PC and FSM normally.
REQ-029 An interrupt pending while in RST_VEC or IMM SHALL wait until the next FETCH.

Reset
REQ-030 i_reset SHALL immediately force PC=0, state=RST_VEC, pending=0, o_instr=0, o_imm=0, o_pc=0, o_valid=0, o_interrupt=0.
REQ-031 Reset asserted mid-IMM or mid-INT SHALL discard the partial instruction; RST_VEC SHALL run on the first edge after release.

Structure
REQ-032 Shared package SHALL hold the state encoding, NOP_INSTR, RESET_VECTOR_ADDR=0, INT_VECTOR_ADDR=1 and IMM_OPCODES.
REQ-033 Decode SHALL use the same IMM_OPCODES definition.
REQ-034 SHALL be a single module: FSM, PC register and output pipeline register inline, no sub-modules.

Verification
REQ-035 Reset release with imem[0]=0x0010 -> first cycle bubble; next cycle o_imem_addr=0x0010; output o_pc=0x0010 one cycle after that.
REQ-036 Two-word instruction at 0x0010 with imm 0xBEEF -> one bubble, then o_instr=first word, o_imm=0xBEEF, o_pc=0x0010; next fetch at 0x0012.
REQ-037 i_interrupt pulse during IMM at 0x0020, imem[1]=0x0100 -> two-word instruction completes, then o_interrupt=1, o_pc=0x0022; next fetch at 0x0100.
REQ-038 i_branch with target 0x0050 together with i_stall -> branch wins; bubble out; next o_imem_addr=0x0050.
REQ-039 i_stall held 3 cycles -> o_instr, o_pc, o_imem_addr unchanged for 3 cycles, then resume at the same PC.
REQ-040 i_reset asserted mid-IMM -> all outputs 0 immediately; RST_VEC re-executes after release.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the decode stage.
// Holds the FSM encoding, fixed vector addresses, the NOP word and the set
// of opcodes whose instructions carry a second (immediate) word.
package fetch_stage_pkg;

  // FSM state encoding
  localparam logic [1:0] RST_VEC = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] IMM     = 2'd2;
  localparam logic [1:0] INT     = 2'd3;

  localparam logic [15:0] NOP_INSTR         = 16'h0000;
  localparam logic [15:0] RESET_VECTOR_ADDR = 16'h0000;
  localparam logic [15:0] INT_VECTOR_ADDR   = 16'h0001;

  // One bit per 5-bit opcode; a set bit marks a two-word instruction.
  // Opcodes 0x1C..0x1F (words 0xE000..0xFFFF) take an immediate word.
  localparam logic [31:0] IMM_OPCODES = 32'hF000_0000;

  function automatic logic is_imm_opcode(input logic [15:0] word);
    return IMM_OPCODES[word[15:11]];
  endfunction

  // Registered output slot towards decode
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        valid;
    logic        interrupt;
  } fetch_out_t;

  localparam fetch_out_t BUBBLE_OUT = '{
    instr:     NOP_INSTR,
    imm:       16'h0000,
    pc:        16'h0000,
    valid:     1'b0,
    interrupt: 1'b0
  };

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, reset/interrupt vector loading,
// two-word instruction assembly and a registered output slot for decode.
// Control priority: reset > branch > stall > flush > interrupt > fetch.
// Stall freezes everything except capture of new interrupt requests.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_branch,
  input  logic [15:0] i_branch_target,
  input  logic        i_interrupt,
  output logic [15:0] o_imem_addr,
  input  logic [15:0] i_imem_data,
  output logic [15:0] o_instr,
  output logic [15:0] o_imm,
  output logic [15:0] o_pc,
  output logic        o_valid,
  output logic        o_interrupt,
  output logic [1:0]  o_dbg_state
);

  logic [1:0]  state, state_n;
  logic [15:0] pc, pc_n;
  logic        pending, pending_n;
  logic        int_q;
  logic [15:0] hold_word, hold_word_n;
  logic [15:0] hold_pc, hold_pc_n;
  fetch_out_t  out_q, out_n;
  logic        int_rise;

  assign int_rise = i_interrupt & ~int_q;

  // Memory address depends on state only: vectors in RST_VEC/INT, else PC
  always_comb begin
    case (state)
      RST_VEC: o_imem_addr = RESET_VECTOR_ADDR;
      INT:     o_imem_addr = INT_VECTOR_ADDR;
      default: o_imem_addr = pc;
    endcase
  end

  // Next-state, PC, pending flag and output slot selection
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    pending_n   = pending | int_rise;
    hold_word_n = hold_word;
    hold_pc_n   = hold_pc;
    out_n       = BUBBLE_OUT;
    if (i_branch) begin
      // Redirect aborts any partial two-word instruction
      pc_n    = i_branch_target;
      state_n = FETCH;
    end else if (i_stall) begin
      out_n = out_q;
    end else begin
      case (state)
        RST_VEC: begin
          pc_n    = i_imem_data;
          state_n = FETCH;
        end
        FETCH: begin
          if (pending && !i_flush) begin
            // Take the interrupt: no fetch, PC kept as return address
            state_n   = INT;
            pending_n = int_rise;
          end else begin
            pc_n = pc + 16'd1;
            if (is_imm_opcode(i_imem_data)) begin
              hold_word_n = i_imem_data;
              hold_pc_n   = pc;
              state_n     = IMM;
            end else begin
              out_n.instr = i_imem_data;
              out_n.pc    = pc;
              out_n.valid = 1'b1;
            end
          end
        end
        IMM: begin
          pc_n        = pc + 16'd1;
          state_n     = FETCH;
          out_n.instr = hold_word;
          out_n.imm   = i_imem_data;
          out_n.pc    = hold_pc;
          out_n.valid = 1'b1;
        end
        default: begin
          // INT: load handler address, emit marker carrying return address
          pc_n            = i_imem_data;
          state_n         = FETCH;
          out_n.pc        = pc;
          out_n.valid     = 1'b1;
          out_n.interrupt = 1'b1;
        end
      endcase
      if (i_flush) out_n = BUBBLE_OUT;
    end
  end

  // State, PC, pending flag and output slot registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= RST_VEC;
      pc        <= 16'h0000;
      pending   <= 1'b0;
      int_q     <= 1'b0;
      hold_word <= NOP_INSTR;
      hold_pc   <= 16'h0000;
      out_q     <= BUBBLE_OUT;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      pending   <= pending_n;
      int_q     <= i_interrupt;
      hold_word <= hold_word_n;
      hold_pc   <= hold_pc_n;
      out_q     <= out_n;
    end
  end

  assign o_instr     = out_q.instr;
  assign o_imm       = out_q.imm;
  assign o_pc        = out_q.pc;
  assign o_valid     = out_q.valid;
  assign o_interrupt = out_q.interrupt;
  assign o_dbg_state = state;

endmodule
